// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Round-robin arbiter granting NREQ requesters one memory transfer
//            at a time, with a bounded wait and timeout error reporting.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int NREQ    = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          req_we,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_wdata,
    output logic [NREQ-1:0]          gnt,
    output logic [NREQ-1:0]          done,
    output logic [DATA_W-1:0]        rdata,
    output logic                     err,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic                     mem_ready,
    input  logic [DATA_W-1:0]        mem_rdata
);

    localparam int         c_idx_w   = $clog2(NREQ);
    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_busy = 2'd1;
    localparam logic [1:0] c_st_resp = 2'd2;
    localparam logic [9:0] c_timeout = 10'(TIMEOUT);

    logic [1:0]         r_state;
    logic [c_idx_w-1:0] r_last;
    logic [c_idx_w-1:0] r_owner;
    logic [9:0]         r_cnt;

    logic               w_found;
    logic [c_idx_w-1:0] w_win;

    // Search starts just past the previous owner, so it ranks last next time.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int i = 1; i <= NREQ; i++) begin
            if (!w_found && req[c_idx_w'((int'(r_last) + i) % NREQ)]) begin
                w_found = 1'b1;
                w_win   = c_idx_w'((int'(r_last) + i) % NREQ);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= c_st_idle;
            r_last    <= c_idx_w'(NREQ - 1);
            r_owner   <= '0;
            r_cnt     <= '0;
            gnt       <= '0;
            done      <= '0;
            rdata     <= '0;
            err       <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_found) begin
                        r_owner   <= w_win;
                        gnt       <= NREQ'(1) << w_win;
                        mem_req   <= 1'b1;
                        mem_we    <= req_we[w_win];
                        mem_addr  <= req_addr[w_win*ADDR_W +: ADDR_W];
                        mem_wdata <= req_wdata[w_win*DATA_W +: DATA_W];
                        r_cnt     <= 10'd1;
                        r_state   <= c_st_busy;
                    end
                end
                c_st_busy: begin
                    // A ready arriving on the timeout cycle still completes cleanly.
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        done    <= gnt;
                        rdata   <= mem_we ? '0 : mem_rdata;
                        err     <= 1'b0;
                        r_state <= c_st_resp;
                    end else if (r_cnt >= c_timeout) begin
                        mem_req <= 1'b0;
                        done    <= gnt;
                        rdata   <= '0;
                        err     <= 1'b1;
                        r_state <= c_st_resp;
                    end else begin
                        r_cnt <= r_cnt + 10'd1;
                    end
                end
                c_st_resp: begin
                    done    <= '0;
                    rdata   <= '0;
                    err     <= 1'b0;
                    gnt     <= '0;
                    r_last  <= r_owner;
                    r_cnt   <= '0;
                    r_state <= c_st_idle;
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Directed self-checking bench for mem_arbiter (NREQ=4, TIMEOUT=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 32;
    localparam int DW   = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic [NREQ-1:0]  req, req_we, gnt, done;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [DW-1:0]    rdata, mem_wdata, mem_rdata;
    logic [AW-1:0]    mem_addr;
    logic             err, mem_req, mem_we, mem_ready;

    int nvec = 0;
    int nerr = 0;

    mem_arbiter #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .gnt(gnt), .done(done), .rdata(rdata), .err(err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_gnt"}, 64'(gnt), 64'h0);
        chk({tag, "_done"}, 64'(done), 64'h0);
        chk({tag, "_rdata"}, 64'(rdata), 64'h0);
        chk({tag, "_err"}, 64'(err), 64'h0);
        chk({tag, "_memreq"}, 64'(mem_req), 64'h0);
    endtask

    initial begin
        int n;
        logic [NREQ-1:0] exp_oh;
        int exp_idx;

        rst = 1'b0; req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        mem_ready = 1'b0; mem_rdata = '0;
        tick(); tick();
        chk_idle_outputs("reset");
        chk("reset_memaddr", 64'(mem_addr), 64'h0);
        chk("reset_memwe", 64'(mem_we), 64'h0);
        rst = 1'b1;
        tick();

        // Single read from requester 0
        req = 4'b0001; req_addr[0*AW +: AW] = 32'h100;
        tick();
        chk("rd_gnt", 64'(gnt), 64'h1);
        chk("rd_memreq", 64'(mem_req), 64'h1);
        chk("rd_memaddr", 64'(mem_addr), 64'h100);
        chk("rd_memwe", 64'(mem_we), 64'h0);
        chk("rd_done_early", 64'(done), 64'h0);
        req = 4'b0000; req_addr = '0;
        mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
        tick();
        chk("rd_done", 64'(done), 64'h1);
        chk("rd_rdata", 64'(rdata), 64'hDEADBEEF);
        chk("rd_err", 64'(err), 64'h0);
        chk("rd_memreq_drop", 64'(mem_req), 64'h0);
        mem_ready = 1'b0; mem_rdata = '0;
        tick();
        chk_idle_outputs("rd_after");

        // Round robin with all four requesting after a fresh reset
        rst = 1'b0; tick(); rst = 1'b1;
        req = 4'b1111; req_we = 4'b0101;
        for (int i = 0; i < NREQ; i++) begin
            req_addr[i*AW +: AW]  = 32'h1000 + 32'(i);
            req_wdata[i*DW +: DW] = 32'h5000 + 32'(i);
        end
        for (int j = 0; j < 5; j++) begin
            exp_idx = j % NREQ;
            exp_oh  = 4'b0001 << exp_idx;
            tick();
            chk("rr_gnt", 64'(gnt), 64'(exp_oh));
            chk("rr_memaddr", 64'(mem_addr), 64'h1000 + 64'(exp_idx));
            chk("rr_memwe", 64'(mem_we), 64'(req_we[exp_idx]));
            chk("rr_memwdata", 64'(mem_wdata), 64'h5000 + 64'(exp_idx));
            mem_ready = 1'b1; mem_rdata = 32'hA0 + 32'(j);
            tick();
            chk("rr_done", 64'(done), 64'(exp_oh));
            chk("rr_rdata", 64'(rdata), req_we[exp_idx] ? 64'h0 : 64'hA0 + 64'(j));
            mem_ready = 1'b0;
            tick();
            chk("rr_done_clear", 64'(done), 64'h0);
        end
        req = '0; req_we = '0;
        tick();

        // Timeout with no mem_ready
        req = 4'b0100; mem_rdata = 32'h12345678;
        tick();
        chk("to_gnt", 64'(gnt), 64'h4);
        req = 4'b0000;
        n = 0;
        while (mem_req && n < 20) begin
            n++;
            tick();
        end
        chk("to_memreq_cycles", 64'(n), 64'd8);
        chk("to_done", 64'(done), 64'h4);
        chk("to_err", 64'(err), 64'h1);
        chk("to_rdata", 64'(rdata), 64'h0);
        tick();
        chk_idle_outputs("to_after");

        // mem_ready coincident with final BUSY cycle
        req = 4'b1000;
        tick();
        chk("tr_gnt", 64'(gnt), 64'h8);
        req = 4'b0000;
        for (int c = 2; c <= 8; c++) tick();
        chk("tr_memreq_c8", 64'(mem_req), 64'h1);
        mem_ready = 1'b1; mem_rdata = 32'hCAFEF00D;
        tick();
        chk("tr_done", 64'(done), 64'h8);
        chk("tr_err", 64'(err), 64'h0);
        chk("tr_rdata", 64'(rdata), 64'hCAFEF00D);
        mem_ready = 1'b0;
        tick();

        // Stray mem_ready in IDLE has no effect
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        chk_idle_outputs("stray_idle");

        // Move last owner to 0, then reset mid-transfer of requester 1
        req = 4'b0001;
        tick();
        req = 4'b0000; mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        tick();
        req = 4'b0010;
        tick();
        chk("rb_gnt", 64'(gnt), 64'h2);
        tick();
        rst = 1'b0; req = 4'b0000;
        #1;
        chk_idle_outputs("rb_async");
        chk("rb_memaddr", 64'(mem_addr), 64'h0);
        chk("rb_memwdata", 64'(mem_wdata), 64'h0);
        @(negedge clk);
        rst = 1'b1; mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        chk_idle_outputs("rb_stray");
        req = 4'b0011;
        tick();
        chk("rb_next_gnt", 64'(gnt), 64'h1);
        req = 4'b0000; mem_ready = 1'b1; mem_rdata = 32'h77;
        tick();
        mem_ready = 1'b0;
        chk("rb_done", 64'(done), 64'h1);
        chk("rb_rdata", 64'(rdata), 64'h77);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter ADDR_W, default 32, address width.
REQ-003 SHALL have parameter DATA_W, default 32, data width.
REQ-004 SHALL have parameter TIMEOUT, default 255, maximum memory wait cycles (1..1023).
REQ-005 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port req  input  NREQ  per-requester transfer request, level.
REQ-008 SHALL have port req_we  input  NREQ  per-requester write enable (1=write).
REQ-009 SHALL have port req_addr  input  NREQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W].
REQ-010 SHALL have port req_wdata  input  NREQ*DATA_W  packed write data, same packing.
REQ-011 SHALL have port gnt  output  NREQ  one-hot current owner, all-zero when idle.
REQ-012 SHALL have port done  output  NREQ  one-cycle completion pulse to owner.
REQ-013 SHALL have port rdata  output  DATA_W  read data, valid while done is high.
REQ-014 SHALL have port err  output  1  timeout flag, valid while done is high.
REQ-015 SHALL have port mem_req  output  1  memory access request.
REQ-016 SHALL have port mem_we  output  1  memory write enable.
REQ-017 SHALL have port mem_addr  output  ADDR_W  memory address.
REQ-018 SHALL have port mem_wdata  output  DATA_W  memory write data.
REQ-019 SHALL have port mem_ready  input  1  memory completion, single cycle.
REQ-020 SHALL have port mem_rdata  input  DATA_W  memory read data, valid with mem_ready.

Function
REQ-021 SHALL implement FSM states IDLE, BUSY, RESP; all outputs registered.
REQ-022 IDLE, any req bit set: SHALL pick winner round-robin, searching from last_owner+1 modulo NREQ; SHALL latch winner's we/addr/wdata, set gnt one-hot, enter BUSY next cycle.
REQ-023 BUSY: SHALL hold mem_req=1 and mem_we/mem_addr/mem_wdata constant from latched values.
REQ-024 BUSY, mem_ready=1: SHALL capture mem_rdata (reads; 0 for writes) into rdata, drop mem_req, enter RESP.
REQ-025 BUSY: SHALL count cycles from 1; at count==TIMEOUT with mem_ready=0, SHALL drop mem_req, set err=1, rdata=0, enter RESP.
REQ-026 mem_ready and timeout in same cycle: mem_ready SHALL win, err=0.
REQ-027 RESP: SHALL assert done[owner]=1 for exactly one cycle with rdata/err valid, update last_owner=owner, clear gnt, return to IDLE.
REQ-028 Minimum latency: req sampled at edge k, mem_ready high in first BUSY cycle -> mem_req high cycle k+1, done high cycle k+2.
REQ-029 No new grant in RESP; a requester holding req after done SHALL be eligible at next IDLE but loses to any other pending requester (round-robin).
REQ-030 Requester inputs changing after grant SHALL be ignored; req deasserted mid-transfer SHALL NOT abort; done still pulses.
REQ-031 mem_ready outside BUSY SHALL be ignored.
REQ-032 done, err, rdata SHALL be zero outside RESP.

Reset
REQ-033 rst low SHALL immediately force IDLE, gnt=0, done=0, rdata=0, err=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, counter=0.
REQ-034 Reset SHALL set last_owner=NREQ-1 so requester 0 has first priority.
REQ-035 Reset mid-BUSY SHALL abandon the transfer with no done pulse; a mem_ready arriving after release SHALL be ignored.

Verification
REQ-036 Single read: req=0001, addr0=0x100, mem_ready 1 cycle after mem_req with mem_rdata=0xDEADBEEF -> mem_addr=0x100, done=0001, rdata=0xDEADBEEF, err=0.
REQ-037 All four requesting continuously after reset -> grant order 0,1,2,3,0; each done pulse one cycle; gnt one-hot.
REQ-038 Timeout: TIMEOUT=8, mem_ready never asserted -> mem_req high exactly 8 cycles, then done pulse with err=1, rdata=0.
REQ-039 mem_ready coincident with 8th BUSY cycle (TIMEOUT=8) -> err=0, rdata=mem_rdata.
REQ-040 rst low during BUSY, stray mem_ready after release -> all outputs 0, no done, next grant to requester 0.
